// File: rtl/viterbi_traceback.sv
// Traceback stage: picks the minimum-metric survivor on each set and streams its oldest bit.
// One cycle from set acceptance to bit_out. Input stalls while an emitted bit is unaccepted; flush drains the rest of the history.
module viterbi_traceback (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] metric_00,
  input  logic [3:0] metric_01,
  input  logic [3:0] metric_10,
  input  logic [3:0] metric_11,
  input  logic [7:0] path_00,
  input  logic [7:0] path_01,
  input  logic [7:0] path_10,
  input  logic [7:0] path_11,
  input  logic       valid_in,
  output logic       in_ready,
  input  logic       flush,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       out_ready,
  output logic [1:0] best_state,
  output logic [3:0] best_metric,
  output logic       flush_done,
  output logic       overrun
);

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  state_t     state;
  logic [2:0] fill_cnt;
  logic [7:0] best_path;
  logic       flush_pending;
  logic [2:0] flush_idx;

  logic [1:0] sel_state;
  logic [3:0] sel_metric;
  logic [7:0] sel_path;
  logic       out_free;
  logic       accept;
  logic       flush_req;
  logic [2:0] flush_start;

  // Strict less-than keeps the earlier (lower) index on ties.
  always_comb begin
    sel_state  = 2'd0;
    sel_metric = metric_00;
    sel_path   = path_00;
    if (metric_01 < sel_metric) begin
      sel_state  = 2'd1;
      sel_metric = metric_01;
      sel_path   = path_01;
    end
    if (metric_10 < sel_metric) begin
      sel_state  = 2'd2;
      sel_metric = metric_10;
      sel_path   = path_10;
    end
    if (metric_11 < sel_metric) begin
      sel_state  = 2'd3;
      sel_metric = metric_11;
      sel_path   = path_11;
    end
  end

  assign out_free    = !bit_valid || out_ready;
  assign in_ready    = rst_n && (state != FLUSH) && !flush_pending && out_free;
  assign accept      = valid_in && in_ready;
  assign flush_req   = flush && (state != FLUSH) && !flush_pending;
  assign flush_start = (state == STREAM) ? 3'd6 : (fill_cnt - 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      fill_cnt      <= 3'd0;
      best_path     <= 8'd0;
      best_state    <= 2'd0;
      best_metric   <= 4'd0;
      bit_out       <= 1'b0;
      bit_valid     <= 1'b0;
      flush_done    <= 1'b0;
      overrun       <= 1'b0;
      flush_pending <= 1'b0;
      flush_idx     <= 3'd0;
    end else begin
      flush_done <= 1'b0;
      if (valid_in && !in_ready)
        overrun <= 1'b1;
      if (bit_valid && out_ready)
        bit_valid <= 1'b0;

      case (state)
        FILL, STREAM: begin
          if (accept) begin
            best_path   <= sel_path;
            best_state  <= sel_state;
            best_metric <= sel_metric;
            if (state == FILL && fill_cnt != 3'd7) begin
              fill_cnt <= fill_cnt + 3'd1;
            end else begin
              state     <= STREAM;
              bit_out   <= sel_path[7];
              bit_valid <= 1'b1;
            end
            if (flush_req)
              flush_pending <= 1'b1;
          end else if (flush_req || flush_pending) begin
            // Drain starts only once the last streamed bit has been taken.
            if (out_free) begin
              if (state == FILL && fill_cnt == 3'd0) begin
                flush_done    <= 1'b1;
                flush_pending <= 1'b0;
              end else begin
                state     <= FLUSH;
                flush_idx <= flush_start;
                bit_out   <= best_path[flush_start];
                bit_valid <= 1'b1;
              end
            end else begin
              flush_pending <= 1'b1;
            end
          end
        end

        FLUSH: begin
          if (bit_valid && out_ready) begin
            if (flush_idx == 3'd0) begin
              state         <= FILL;
              fill_cnt      <= 3'd0;
              flush_pending <= 1'b0;
              flush_done    <= 1'b1;
            end else begin
              flush_idx <= flush_idx - 3'd1;
              bit_out   <= best_path[flush_idx - 3'd1];
              bit_valid <= 1'b1;
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: hand-computed selections, streaming, flush drains and reset abandon.
module tb_viterbi_traceback;

  logic       clk;
  logic       rst_n;
  logic [3:0] metric_00, metric_01, metric_10, metric_11;
  logic [7:0] path_00, path_01, path_10, path_11;
  logic       valid_in;
  logic       in_ready;
  logic       flush;
  logic       bit_out;
  logic       bit_valid;
  logic       out_ready;
  logic [1:0] best_state;
  logic [3:0] best_metric;
  logic       flush_done;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  viterbi_traceback dut (
    .clk(clk), .rst_n(rst_n),
    .metric_00(metric_00), .metric_01(metric_01), .metric_10(metric_10), .metric_11(metric_11),
    .path_00(path_00), .path_01(path_01), .path_10(path_10), .path_11(path_11),
    .valid_in(valid_in), .in_ready(in_ready), .flush(flush),
    .bit_out(bit_out), .bit_valid(bit_valid), .out_ready(out_ready),
    .best_state(best_state), .best_metric(best_metric),
    .flush_done(flush_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2,
                        input logic [3:0] m3, input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
    metric_00 = m0; metric_01 = m1; metric_10 = m2; metric_11 = m3;
    path_00 = p0; path_01 = p1; path_10 = p2; path_11 = p3;
  endtask

  initial begin
    logic [6:0] exp_b3;
    logic       seen_bit;
    exp_b3 = 7'b0110011;

    rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; out_ready = 1'b1;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_best_state", best_state, 0);
    chk("rst_best_metric", best_metric, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // First set: tie between 01 and 11 at metric 1, lower index wins.
    set_in(4'd3, 4'd1, 4'd2, 4'd1, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("s1_best_state", best_state, 1);
    chk("s1_best_metric", best_metric, 1);
    chk("s1_best_path", dut.best_path, 8'h3C);
    chk("s1_fill_cnt", dut.fill_cnt, 1);
    chk("s1_bit_valid", bit_valid, 0);

    // Sets 2..7 keep filling.
    set_in(4'd5, 4'd5, 4'd5, 4'd5, 8'h11, 8'h22, 8'h33, 8'h44);
    valid_in = 1'b1;
    for (int i = 0; i < 6; i++) step();
    valid_in = 1'b0;
    chk("s7_fill_cnt", dut.fill_cnt, 7);
    chk("s7_bit_valid", bit_valid, 0);
    chk("s7_best_path", dut.best_path, 8'h11);

    // Eighth set: tie 10/11 at metric 2, path B3 -> STREAM, bit 1.
    set_in(4'd9, 4'd9, 4'd2, 4'd2, 8'h00, 8'h00, 8'hB3, 8'h4C);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("s8_bit_valid", bit_valid, 1);
    chk("s8_bit_out", bit_out, 1);
    chk("s8_best_state", best_state, 2);
    chk("s8_best_metric", best_metric, 2);
    chk("s8_state_stream", dut.state, 1);
    step();
    chk("s8_bit_taken", bit_valid, 0);

    // Stalled output, then a set dropped while in_ready is low.
    out_ready = 1'b0;
    set_in(4'd1, 4'd0, 4'd3, 4'd3, 8'h00, 8'hB3, 8'h00, 8'h00);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("str_bit_valid", bit_valid, 1);
    chk("str_bit_out", bit_out, 1);
    chk("stall_in_ready", in_ready, 0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("drop_overrun", overrun, 1);
    chk("drop_bit_out_held", bit_out, 1);
    chk("drop_bit_valid_held", bit_valid, 1);
    chk("drop_best_path", dut.best_path, 8'hB3);
    chk("drop_best_state", best_state, 1);
    chk("drop_best_metric", best_metric, 0);

    // Flush from STREAM: bits 6..0 of B3.
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 0);
    for (int i = 0; i < 7; i++) begin
      chk("stream_flush_valid", bit_valid, 1);
      chk("stream_flush_bit", bit_out, exp_b3[6-i]);
      chk("stream_flush_no_done", flush_done, 0);
      step();
    end
    chk("stream_flush_done", flush_done, 1);
    chk("stream_flush_end_valid", bit_valid, 0);
    chk("stream_flush_state", dut.state, 0);
    chk("stream_flush_fill_cnt", dut.fill_cnt, 0);
    step();
    chk("stream_flush_done_pulse", flush_done, 0);

    // Three FILL sets, best path 05 (tie 01/10), then flush with a stall.
    set_in(4'd7, 4'd3, 4'd3, 4'd8, 8'h00, 8'h05, 8'hAA, 8'hAA);
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    valid_in = 1'b0;
    chk("fill3_cnt", dut.fill_cnt, 3);
    chk("fill3_best_state", best_state, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fill_flush_b2_valid", bit_valid, 1);
    chk("fill_flush_b2", bit_out, 1);
    out_ready = 1'b0;
    step();
    chk("fill_flush_hold_valid", bit_valid, 1);
    chk("fill_flush_hold_bit", bit_out, 1);
    out_ready = 1'b1;
    step();
    chk("fill_flush_b1", bit_out, 0);
    step();
    chk("fill_flush_b0", bit_out, 1);
    chk("fill_flush_b0_valid", bit_valid, 1);
    step();
    chk("fill_flush_done", flush_done, 1);
    chk("fill_flush_end_valid", bit_valid, 0);
    step();

    // Flush with nothing filled: done pulse only.
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("empty_flush_done", flush_done, 1);
    chk("empty_flush_valid", bit_valid, 0);
    chk("empty_flush_state", dut.state, 0);
    step();
    chk("empty_flush_done_pulse", flush_done, 0);

    // Flush arriving with a set: set captured first, then one bit drained.
    set_in(4'd0, 4'd1, 4'd1, 4'd1, 8'h41, 8'h00, 8'h00, 8'h00);
    valid_in = 1'b1;
    flush = 1'b1;
    step();
    valid_in = 1'b0;
    flush = 1'b0;
    chk("pend_fill_cnt", dut.fill_cnt, 1);
    chk("pend_in_ready", in_ready, 0);
    chk("pend_bit_valid", bit_valid, 0);
    step();
    chk("pend_bit_valid2", bit_valid, 1);
    chk("pend_bit", bit_out, 1);
    step();
    chk("pend_done", flush_done, 1);
    step();

    // Reset in the middle of a STREAM flush.
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 8'hF0, 8'h00, 8'h00, 8'h00);
    valid_in = 1'b1;
    for (int i = 0; i < 8; i++) step();
    valid_in = 1'b0;
    chk("rf_stream_bit", bit_out, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("rf_b6", bit_out, 1);
    step();
    chk("rf_b5", bit_out, 1);
    step();
    chk("rf_b4_valid", bit_valid, 1);
    chk("rf_overrun_sticky", overrun, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rf_bit_valid", bit_valid, 0);
    chk("rf_in_ready", in_ready, 0);
    chk("rf_overrun", overrun, 0);
    chk("rf_state", dut.state, 0);
    chk("rf_fill_cnt", dut.fill_cnt, 0);
    chk("rf_best_path", dut.best_path, 0);
    chk("rf_best_state", best_state, 0);
    chk("rf_best_metric", best_metric, 0);
    chk("rf_bit_out", bit_out, 0);
    chk("rf_pending", dut.flush_pending, 0);
    step();
    rst_n = 1'b1;
    seen_bit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bit_valid || flush_done) seen_bit = 1'b1;
    end
    chk("rf_no_bits_after", seen_bit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
